// File: rtl/chinpo_control_unit_mw.sv
// CHINPO multicycle control FSM with memory-wait timeout, prioritised IRQs and RETI.
// Latency: Moore outputs from state (MemReady gates PCWrite/IRWrite/IrqAck/BusError); stalls in wait states until MemReady or timeout.
// Optional nested interrupts via `define CHINPO_NESTED_IRQ_EN.
module chinpo_control_unit_mw #(
    parameter int NUM_IRQ      = 4,
    parameter int IRQ_ID_W     = 2,
    parameter int WAIT_TIMEOUT = 15,
    parameter int STATE_W      = 5
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [3:0]          Opcode,
    input  logic [3:0]          IR,
    input  logic                Branch,
    input  logic [NUM_IRQ-1:0]  Irq,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemData,
    output logic                ALUSrcA,
    output logic                WriteDataSrc,
    output logic                CLRA,
    output logic                CLRB,
    output logic                MVA,
    output logic                MVB,
    output logic [2:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          MemAddr,
    output logic [1:0]          PcIn,
    output logic [NUM_IRQ-1:0]  IrqAck,
    output logic [IRQ_ID_W-1:0] IrqId,
    output logic                InService,
    output logic                BusError,
    output logic [STATE_W-1:0]  CurrentState
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = STATE_W'(0),
        S_FETCH  = STATE_W'(1),
        S_DECODE = STATE_W'(2),
        S_DR     = STATE_W'(3),
        S_I      = STATE_W'(4),
        S_MEM    = STATE_W'(5),
        S_SW_WR  = STATE_W'(6),
        S_LW_RD  = STATE_W'(7),
        S_LW_WB  = STATE_W'(8),
        S_WB     = STATE_W'(9),
        S_JAL    = STATE_W'(10),
        S_JR     = STATE_W'(11),
        S_J      = STATE_W'(12),
        S_BEQ    = STATE_W'(13),
        S_INTR   = STATE_W'(14)
    } state_t;

    state_t              state;
    state_t              next_state;
    state_t              done_state;
    logic [7:0]          wait_cnt;
    logic [IRQ_ID_W-1:0] irq_id;
    logic                in_service;
    logic [IRQ_ID_W-1:0] sel_id;
    logic                is_wait;
    logic                timeout;
    logic                take_irq;
    logic                reti;

`ifdef CHINPO_NESTED_IRQ_EN
    logic [IRQ_ID_W-1:0] save_id;
    logic                save_vld;
`endif

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (Irq[i]) sel_id = IRQ_ID_W'(i);
        end
    end

    assign is_wait = (state == S_FETCH) || (state == S_SW_WR) ||
                     (state == S_LW_RD) || (state == S_INTR);
    // Timeout fires on the WAIT_TIMEOUT-th consecutive stalled cycle.
    assign timeout = is_wait && !MemReady && (wait_cnt == 8'(WAIT_TIMEOUT - 1));
    assign reti    = (state == S_JR) && (Opcode == 4'd3) && (IR == 4'hF);

`ifdef CHINPO_NESTED_IRQ_EN
    // Only one level can be saved, so nesting is refused while a save is held.
    assign take_irq = (|Irq) && (!in_service || (!save_vld && (sel_id < irq_id)));
`else
    assign take_irq = (|Irq) && !in_service;
`endif

    assign done_state = take_irq ? S_INTR : S_FETCH;

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:  next_state = S_FETCH;
            S_FETCH:  next_state = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    4'd3:                      next_state = S_JR;
                    4'd4, 4'd9, 4'd10, 4'd13:  next_state = S_I;
                    4'd0, 4'd1, 4'd2, 4'd5,
                    4'd6, 4'd7:                next_state = S_DR;
                    4'd8, 4'd11:               next_state = S_J;
                    4'd14, 4'd15:              next_state = S_MEM;
                    4'd12:                     next_state = Branch ? S_BEQ : S_FETCH;
                    default:                   next_state = S_FETCH;
                endcase
            end
            S_DR, S_I: next_state = S_WB;
            S_MEM:     next_state = (Opcode == 4'd15) ? S_SW_WR : S_LW_RD;
            S_SW_WR:   next_state = MemReady ? done_state : (timeout ? S_FETCH : S_SW_WR);
            S_LW_RD:   next_state = MemReady ? S_LW_WB : (timeout ? S_FETCH : S_LW_RD);
            S_LW_WB, S_WB, S_JAL, S_BEQ: next_state = done_state;
            S_JR:      next_state = S_J;
            S_J:       next_state = (Opcode == 4'd11) ? S_JAL : done_state;
            S_INTR:    next_state = (MemReady || timeout) ? S_FETCH : S_INTR;
            default:   next_state = S_RESET;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_RESET;
            wait_cnt   <= 8'd0;
            irq_id     <= '0;
            in_service <= 1'b0;
`ifdef CHINPO_NESTED_IRQ_EN
            save_id    <= '0;
            save_vld   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if ((next_state != state) || timeout) begin
                wait_cnt <= 8'd0;
            end else if (is_wait && !MemReady) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((next_state == S_INTR) && (state != S_INTR)) begin
                irq_id     <= sel_id;
                in_service <= 1'b1;
`ifdef CHINPO_NESTED_IRQ_EN
                if (in_service) begin
                    save_id  <= irq_id;
                    save_vld <= 1'b1;
                end
`endif
            end else if (reti) begin
`ifdef CHINPO_NESTED_IRQ_EN
                if (save_vld) begin
                    irq_id   <= save_id;
                    save_vld <= 1'b0;
                end else begin
                    in_service <= 1'b0;
                end
`else
                in_service <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemData      = 1'b0;
        ALUSrcA      = 1'b0;
        WriteDataSrc = 1'b0;
        {MVA, MVB, CLRA, CLRB} = 4'b0000;
        ALUSrcB      = 3'd0;
        ALUOp        = 2'd0;
        MemAddr      = 2'd0;
        PcIn         = 2'd0;
        IrqAck       = '0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 3'd4;
                PCWrite = MemReady;
                IRWrite = MemReady;
            end
            S_DECODE: ALUSrcB = 3'd3;
            S_DR: begin
                ALUOp   = 2'd2;
                ALUSrcA = 1'b1;
                {MVA, MVB, CLRA, CLRB} = IR;
            end
            S_I: begin
                ALUOp   = 2'd2;
                ALUSrcA = 1'b1;
                ALUSrcB = 3'd1;
            end
            S_MEM: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 3'd3;
            end
            S_SW_WR: begin
                MemAddr  = 2'd1;
                MemWrite = 1'b1;
            end
            S_LW_RD: begin
                MemAddr = 2'd1;
                MemRead = 1'b1;
            end
            S_LW_WB: begin
                RegWrite     = 1'b1;
                WriteDataSrc = 1'b1;
            end
            S_WB, S_JAL: RegWrite = 1'b1;
            S_JR: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd3;
                {MVA, MVB, CLRA, CLRB} = IR;
            end
            S_J: begin
                PCWrite = 1'b1;
                ALUOp   = 2'd3;
                PcIn    = 2'd1;
            end
            S_BEQ: PCWrite = 1'b1;
            S_INTR: begin
                PCWrite  = MemReady;
                MemWrite = 1'b1;
                MemData  = 1'b1;
                MemAddr  = 2'd3;
                PcIn     = 2'd2;
                IrqAck   = MemReady ? (NUM_IRQ'(1) << irq_id) : '0;
            end
            default: ;
        endcase
    end

    assign BusError     = timeout;
    assign IrqId        = irq_id;
    assign InService    = in_service;
    assign CurrentState = state;

endmodule

// File: tb/tb_chinpo_control_unit_mw.sv
// Directed table-driven bench for chinpo_control_unit_mw plus reset, timeout and interrupt sequences.
module tb_chinpo_control_unit_mw;

    logic       CLK;
    logic       Reset_n;
    logic [3:0] Opcode;
    logic [3:0] IR;
    logic       Branch;
    logic [3:0] Irq;
    logic       MemReady;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemData;
    logic       ALUSrcA, WriteDataSrc, CLRA, CLRB, MVA, MVB;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp, MemAddr, PcIn;
    logic [3:0] IrqAck;
    logic [1:0] IrqId;
    logic       InService, BusError;
    logic [4:0] CurrentState;

    int checks = 0;
    int errors = 0;

    chinpo_control_unit_mw #(.NUM_IRQ(4), .IRQ_ID_W(2), .WAIT_TIMEOUT(15), .STATE_W(5)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .IR(IR), .Branch(Branch),
        .Irq(Irq), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemData(MemData),
        .ALUSrcA(ALUSrcA), .WriteDataSrc(WriteDataSrc), .CLRA(CLRA), .CLRB(CLRB),
        .MVA(MVA), .MVB(MVB), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemAddr(MemAddr),
        .PcIn(PcIn), .IrqAck(IrqAck), .IrqId(IrqId), .InService(InService),
        .BusError(BusError), .CurrentState(CurrentState)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [20:0] mk(input logic pcw, irw, rw, mrd, mwr, mdat, asa, wds,
                                       input logic [3:0] mvclr, input logic [2:0] asb,
                                       input logic [1:0] aop, maddr, pcin);
        return {pcw, irw, rw, mrd, mwr, mdat, asa, wds, mvclr, asb, aop, maddr, pcin};
    endfunction

    localparam logic [20:0] C_NONE   = mk(0,0,0,0,0,0,0,0,4'h0,3'd0,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_FETCH1 = mk(1,1,0,1,0,0,0,0,4'h0,3'd4,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_FETCH0 = mk(0,0,0,1,0,0,0,0,4'h0,3'd4,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_DEC    = mk(0,0,0,0,0,0,0,0,4'h0,3'd3,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_I      = mk(0,0,0,0,0,0,1,0,4'h0,3'd1,2'd2,2'd0,2'd0);
    localparam logic [20:0] C_DR_A   = mk(0,0,0,0,0,0,1,0,4'hA,3'd0,2'd2,2'd0,2'd0);
    localparam logic [20:0] C_WB     = mk(0,0,1,0,0,0,0,0,4'h0,3'd0,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_MEM    = mk(0,0,0,0,0,0,1,0,4'h0,3'd3,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_LWRD   = mk(0,0,0,1,0,0,0,0,4'h0,3'd0,2'd0,2'd1,2'd0);
    localparam logic [20:0] C_LWWB   = mk(0,0,1,0,0,0,0,1,4'h0,3'd0,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_SW     = mk(0,0,0,0,1,0,0,0,4'h0,3'd0,2'd0,2'd1,2'd0);
    localparam logic [20:0] C_JR_F   = mk(0,0,0,0,0,0,1,0,4'hF,3'd0,2'd3,2'd0,2'd0);
    localparam logic [20:0] C_J      = mk(1,0,0,0,0,0,0,0,4'h0,3'd0,2'd3,2'd0,2'd1);
    localparam logic [20:0] C_BEQ    = mk(1,0,0,0,0,0,0,0,4'h0,3'd0,2'd0,2'd0,2'd0);
    localparam logic [20:0] C_INTR1  = mk(1,0,0,0,1,1,0,0,4'h0,3'd0,2'd0,2'd3,2'd2);
    localparam logic [20:0] C_INTR0  = mk(0,0,0,0,1,1,0,0,4'h0,3'd0,2'd0,2'd3,2'd2);

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  ir;
        logic        br;
        logic [3:0]  irq;
        logic        mr;
        logic [4:0]  st;
        logic [20:0] ctl;
        logic [3:0]  ack;
        logic [1:0]  id;
        logic        insvc;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic [3:0] op, ir, input logic br, input logic [3:0] irq,
                               input logic mr, input logic [4:0] st, input logic [20:0] ctl,
                               input logic [3:0] ack, input logic [1:0] id, input logic insvc);
        vec_t r;
        r.op = op; r.ir = ir; r.br = br; r.irq = irq; r.mr = mr;
        r.st = st; r.ctl = ctl; r.ack = ack; r.id = id; r.insvc = insvc;
        return r;
    endfunction

    function automatic logic [20:0] act_ctl();
        return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemData, ALUSrcA, WriteDataSrc,
                MVA, MVB, CLRA, CLRB, ALUSrcB, ALUOp, MemAddr, PcIn};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, ir, input logic br, input logic [3:0] irq, input logic mr);
        @(negedge CLK);
        Opcode = op; IR = ir; Branch = br; Irq = irq; MemReady = mr;
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int berr_n, berr_at, wr_n, ack_n;
        Reset_n = 1'b0; Opcode = 4'd0; IR = 4'd0; Branch = 1'b0; Irq = 4'd0; MemReady = 1'b0;

        //     op    ir    br  irq   mr  st     ctl       ack   id  ins
        tv.push_back(v(4'd4, 4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 0, 0));
        tv.push_back(v(4'd4, 4'h0, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 0, 0));
        tv.push_back(v(4'd4, 4'h0, 0, 4'h0, 1, 5'd4,  C_I,      4'h0, 0, 0));
        tv.push_back(v(4'd4, 4'h0, 0, 4'h0, 1, 5'd9,  C_WB,     4'h0, 0, 0));
        tv.push_back(v(4'd0, 4'hA, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 0, 0));
        tv.push_back(v(4'd0, 4'hA, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 0, 0));
        tv.push_back(v(4'd0, 4'hA, 0, 4'h0, 1, 5'd3,  C_DR_A,   4'h0, 0, 0));
        tv.push_back(v(4'd0, 4'hA, 0, 4'h6, 1, 5'd9,  C_WB,     4'h0, 0, 0));
        tv.push_back(v(4'd0, 4'h0, 0, 4'h6, 0, 5'd14, C_INTR0,  4'h0, 1, 1));
        tv.push_back(v(4'd0, 4'h0, 0, 4'h0, 1, 5'd14, C_INTR1,  4'h2, 1, 1));
        tv.push_back(v(4'd12,4'h0, 1, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 1));
        tv.push_back(v(4'd12,4'h0, 1, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 1));
        tv.push_back(v(4'd12,4'h0, 1, 4'h4, 1, 5'd13, C_BEQ,    4'h0, 1, 1));
        tv.push_back(v(4'd3, 4'hF, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 1));
        tv.push_back(v(4'd3, 4'hF, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 1));
        tv.push_back(v(4'd3, 4'hF, 0, 4'h0, 1, 5'd11, C_JR_F,   4'h0, 1, 1));
        tv.push_back(v(4'd3, 4'hF, 0, 4'h0, 1, 5'd12, C_J,      4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 1, 5'd5,  C_MEM,    4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 0, 5'd7,  C_LWRD,   4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 0, 5'd7,  C_LWRD,   4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 0, 5'd7,  C_LWRD,   4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 1, 5'd7,  C_LWRD,   4'h0, 1, 0));
        tv.push_back(v(4'd14,4'h0, 0, 4'h0, 1, 5'd8,  C_LWWB,   4'h0, 1, 0));
        tv.push_back(v(4'd15,4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 0));
        tv.push_back(v(4'd15,4'h0, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 0));
        tv.push_back(v(4'd15,4'h0, 0, 4'h0, 1, 5'd5,  C_MEM,    4'h0, 1, 0));
        tv.push_back(v(4'd15,4'h0, 0, 4'h0, 1, 5'd6,  C_SW,     4'h0, 1, 0));
        tv.push_back(v(4'd12,4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 0));
        tv.push_back(v(4'd12,4'h0, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 0));
        tv.push_back(v(4'd11,4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 0));
        tv.push_back(v(4'd11,4'h0, 0, 4'h0, 1, 5'd2,  C_DEC,    4'h0, 1, 0));
        tv.push_back(v(4'd11,4'h0, 0, 4'h0, 1, 5'd12, C_J,      4'h0, 1, 0));
        tv.push_back(v(4'd11,4'h0, 0, 4'h0, 1, 5'd10, C_WB,     4'h0, 1, 0));
        tv.push_back(v(4'd9, 4'h0, 0, 4'h0, 1, 5'd1,  C_FETCH1, 4'h0, 1, 0));
        tv.push_back(v(4'd9, 4'h0, 0, 4'h1, 1, 5'd2,  C_DEC,    4'h0, 1, 0));
        tv.push_back(v(4'd9, 4'h0, 0, 4'h1, 1, 5'd4,  C_I,      4'h0, 1, 0));
        tv.push_back(v(4'd9, 4'h0, 0, 4'h0, 1, 5'd9,  C_WB,     4'h0, 1, 0));
        tv.push_back(v(4'd4, 4'h0, 0, 4'h0, 0, 5'd1,  C_FETCH0, 4'h0, 1, 0));

        // Reset state
        @(negedge CLK);
        #1;
        chk("reset_state", {CurrentState, act_ctl(), IrqAck, IrqId, InService, BusError},
            {5'd0, C_NONE, 4'h0, 2'd0, 1'b0, 1'b0});
        Reset_n = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].op, tv[i].ir, tv[i].br, tv[i].irq, tv[i].mr);
            chk($sformatf("vec%0d", i), {CurrentState, act_ctl(), IrqAck, IrqId, InService, BusError},
                {tv[i].st, tv[i].ctl, tv[i].ack, tv[i].id, tv[i].insvc, 1'b0});
        end

        // Asynchronous reset in the middle of a stalled load
        drive(4'd14, 4'h0, 0, 4'h0, 1);
        drive(4'd14, 4'h0, 0, 4'h0, 1);
        drive(4'd14, 4'h0, 0, 4'h0, 1);
        drive(4'd14, 4'h0, 0, 4'h0, 0);
        chk("lw_rd_stall", {CurrentState, MemRead}, {5'd7, 1'b1});
        #2 Reset_n = 1'b0;
        #1;
        chk("reset_mid_lw", {CurrentState, MemRead, IrqId, InService}, {5'd0, 1'b0, 2'd0, 1'b0});
        @(negedge CLK);
        #1 Reset_n = 1'b1;
        chk("reset_held", CurrentState, 5'd0);

        // Fetch stuck waiting: one BusError on wait cycle 15, no writes
        berr_n = 0; berr_at = 0; wr_n = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(4'd0, 4'h0, 0, 4'h0, 0);
            if (k == 1) chk("fetch_after_release", CurrentState, 5'd1);
            if (BusError) begin berr_n++; berr_at = k; end
            if (PCWrite || IRWrite || RegWrite) wr_n++;
        end
        chk("fetch_to_berr_count", berr_n, 1);
        chk("fetch_to_berr_cycle", berr_at, 15);
        chk("fetch_to_no_write", wr_n, 0);
        chk("fetch_to_state", CurrentState, 5'd1);

        // Interrupt entry that times out keeps InService and never acks
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h2, 1);
        berr_n = 0; ack_n = 0; wr_n = 0;
        for (int k = 1; k <= 15; k++) begin
            drive(4'd0, 4'h0, 0, 4'h0, 0);
            if (k == 1) chk("intr_entry", {CurrentState, IrqId, InService}, {5'd14, 2'd1, 1'b1});
            if (BusError) berr_n++;
            if (IrqAck != 4'h0) ack_n++;
            if (PCWrite) wr_n++;
        end
        chk("intr_to_berr", berr_n, 1);
        chk("intr_to_noack", ack_n + wr_n, 0);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        chk("intr_to_after", {CurrentState, IrqId, InService}, {5'd1, 2'd1, 1'b1});

        // Higher-priority request while IRQ 2 is in service
        do_reset();
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h4, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        chk("irq2_ack", {CurrentState, IrqAck, IrqId, InService}, {5'd14, 4'h4, 2'd2, 1'b1});
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        drive(4'd0, 4'h0, 0, 4'h1, 1);
`ifdef CHINPO_NESTED_IRQ_EN
        drive(4'd0, 4'h0, 0, 4'h0, 1);
        chk("nested_taken", {CurrentState, IrqAck, IrqId, InService}, {5'd14, 4'h1, 2'd0, 1'b1});
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        chk("nested_fetch", CurrentState, 5'd1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        chk("reti_restore", {CurrentState, IrqId, InService}, {5'd12, 2'd2, 1'b1});
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        chk("reti_final", {CurrentState, IrqId, InService}, {5'd12, 2'd2, 1'b0});
`else
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        chk("irq0_ignored", {CurrentState, IrqId, InService}, {5'd1, 2'd2, 1'b1});
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        drive(4'd3, 4'hF, 0, 4'h0, 1);
        chk("reti_clear", {CurrentState, IrqId, InService}, {5'd12, 2'd2, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
